// File: rtl/mac_multiplex_pkg.sv
// Shared types for the mac_multiplex result drain: FSM states, precision-mode
// encodings and the mode-to-lane-count mapping.
package mac_multiplex_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, CAPTURE} st_t;

   localparam logic [1:0] MODE_1LANE = 2'd0;
   localparam logic [1:0] MODE_2LANE = 2'd1;
   localparam logic [1:0] MODE_4LANE = 2'd3;

   function automatic logic [2:0] lane_count(input logic [1:0] aw);
      case (aw)
         MODE_1LANE:       return 3'd1;
         MODE_2LANE:       return 3'd2;
         MODE_4LANE, 2'd2: return 3'd4;
         default:          return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mac_drain_serializer.sv
// Holds one captured accumulator word and streams its sign-extended
// sub-accumulator lanes out over valid/ready, lane 0 first.
module mac_drain_serializer
   import mac_multiplex_pkg::*;
#(
   parameter int Z_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [Z_WIDTH-1:0] z,
   input  logic [1:0]         aw,
   input  logic               res_ready,
   output logic               res_valid,
   output logic [Z_WIDTH-1:0] res_data,
   output logic [1:0]         res_lane,
   output logic               res_last
);

   localparam int W2 = Z_WIDTH / 2;
   localparam int W4 = Z_WIDTH / 4;

   logic [Z_WIDTH-1:0]            zr;
   logic [1:0]                    idx, nl_last;
   logic [3:0][Z_WIDTH-1:0]       ext4;
   logic [1:0][Z_WIDTH-1:0]       ext2;

   for (genvar i = 0; i < 4; i++) begin : g_l4
      assign ext4[i] = {{(Z_WIDTH-W4){zr[(i+1)*W4-1]}}, zr[i*W4 +: W4]};
   end
   for (genvar i = 0; i < 2; i++) begin : g_l2
      assign ext2[i] = {{(Z_WIDTH-W2){zr[(i+1)*W2-1]}}, zr[i*W2 +: W2]};
   end

   // The load is only issued while empty, so it never races a pending beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         zr        <= '0;
         idx       <= '0;
         nl_last   <= '0;
         res_valid <= 1'b0;
      end else if (load) begin
         zr        <= z;
         idx       <= '0;
         nl_last   <= 2'(lane_count(aw) - 3'd1);
         res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
         if (idx == nl_last) res_valid <= 1'b0;
         else                idx       <= idx + 2'd1;
      end
   end

   always_comb begin
      res_data = zr;
      case (nl_last)
         2'd1:    res_data = ext2[idx[0]];
         2'd3:    res_data = ext4[idx];
         default: res_data = zr;
      endcase
   end

   assign res_lane = idx;
   assign res_last = res_valid && (idx == nl_last);

endmodule

// File: rtl/mac_multiplex_drain.sv
// Closes MAC accumulation bursts, clears the accumulator and hands z to the
// lane serializer. Optional MAC_DRAIN_PERF_EN adds a FLUSH backpressure counter.
module mac_multiplex_drain
   import mac_multiplex_pkg::*;
#(
   parameter int Z_WIDTH       = 32,
   parameter int ACC_LEN_WIDTH = 8,
   parameter int MAC_LAT       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               config_aw,
   input  logic [ACC_LEN_WIDTH-1:0] acc_len,
   input  logic                     op_valid,
   output logic                     op_ready,
   output logic                     mac_accu_rst,
   input  logic [Z_WIDTH-1:0]       z,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [Z_WIDTH-1:0]       res_data,
   output logic [1:0]               res_lane,
   output logic                     res_last
`ifdef MAC_DRAIN_PERF_EN
   ,output logic [15:0]             stall_cnt
`endif
);

   st_t                      state;
   logic [ACC_LEN_WIDTH-1:0] cnt, burst_len, eff_len;
   logic [1:0]               burst_aw, flush_cnt;
   logic                     issue, wait_done;

   assign issue   = op_valid & op_ready;
   assign eff_len = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
   // flush_cnt counts from the cycle after the last issue; capture lands on
   // last issue + MAC_LAT, but never earlier than one FLUSH cycle.
   assign wait_done = (int'(flush_cnt) + 2) >= MAC_LAT;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         op_ready     <= 1'b0;
         mac_accu_rst <= 1'b0;
         cnt          <= '0;
         burst_len    <= '0;
         burst_aw     <= '0;
         flush_cnt    <= '0;
      end else begin
         mac_accu_rst <= 1'b0;
         case (state)
            IDLE: begin
               op_ready <= 1'b1;
               if (issue) begin
                  burst_aw  <= config_aw;
                  burst_len <= eff_len;
                  cnt       <= ACC_LEN_WIDTH'(1);
                  flush_cnt <= '0;
                  if (eff_len == ACC_LEN_WIDTH'(1)) begin
                     state    <= FLUSH;
                     op_ready <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: if (issue) begin
               cnt <= cnt + ACC_LEN_WIDTH'(1);
               if (cnt + ACC_LEN_WIDTH'(1) == burst_len) begin
                  state     <= FLUSH;
                  op_ready  <= 1'b0;
                  flush_cnt <= '0;
               end
            end
            FLUSH: begin
               if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
               if (wait_done && !res_valid) begin
                  state        <= CAPTURE;
                  mac_accu_rst <= 1'b1;
               end
            end
            CAPTURE: begin
               state    <= IDLE;
               op_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MAC_DRAIN_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (state == FLUSH && wait_done && res_valid && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

   // mac_accu_rst is high exactly in the CAPTURE cycle, so it doubles as the load strobe.
   mac_drain_serializer #(.Z_WIDTH(Z_WIDTH)) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (mac_accu_rst),
      .z         (z),
      .aw        (burst_aw),
      .res_ready (res_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_lane  (res_lane),
      .res_last  (res_last)
   );

endmodule

// File: tb/tb_mac_multiplex_drain.sv
// Bench for mac_multiplex_drain: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mac_multiplex_drain;

   localparam int ZW = 32, ALW = 8, LAT = 2;
   localparam int LAT_EFF = (LAT < 2) ? 2 : LAT;

   logic           clk = 0, rst = 1;
   logic [1:0]     config_aw = 0;
   logic [ALW-1:0] acc_len = 0;
   logic           op_valid = 0, res_ready = 0;
   logic [ZW-1:0]  z = 0;
   logic           op_ready, mac_accu_rst, res_valid, res_last;
   logic [ZW-1:0]  res_data;
   logic [1:0]     res_lane;
`ifdef MAC_DRAIN_PERF_EN
   logic [15:0]    stall_cnt;
`endif

   mac_multiplex_drain #(.Z_WIDTH(ZW), .ACC_LEN_WIDTH(ALW), .MAC_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .config_aw(config_aw), .acc_len(acc_len),
      .op_valid(op_valid), .op_ready(op_ready), .mac_accu_rst(mac_accu_rst),
      .z(z), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_lane(res_lane), .res_last(res_last)
`ifdef MAC_DRAIN_PERF_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] d; logic [1:0] l; logic last; } beat_t;

   int total = 0, bad = 0, cyc = 0;
   bit chk_en = 0;

   // reference model state
   beat_t mq[$];
   bit    m_after_rst = 1, m_closed = 0, m_cap = 0;
   int    m_n = 0, m_len = 1, m_last_iss = 0, m_stall = 0;
   logic [1:0] m_aw = 0;

   // observation logs for literal checks
   int    iss_log[$], arst_log[$];
   beat_t bl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tmo(input string nm);
      total++; bad++;
      $display("FAIL %s: timed out (cyc %0d)", nm, cyc);
   endtask

   task automatic push_lanes(input logic [31:0] zv, input logic [1:0] aw);
      int n, w;
      logic [63:0] m;
      logic [31:0] v;
      n = (aw == 0) ? 1 : (aw == 1) ? 2 : 4;
      w = 32 / n;
      m = (64'd1 << w) - 64'd1;
      for (int i = 0; i < n; i++) begin
         v = 32'((64'(zv) >> (i * w)) & m);
         if (v[w-1]) v = v | ~32'(m);
         mq.push_back('{v, 2'(i), (i == n - 1)});
      end
   endtask

   always @(negedge clk) begin : cmp
      bit e_rdy, qe;
      if (chk_en) begin
         e_rdy = !m_after_rst && !m_closed;
         qe    = (mq.size() == 0);
         chk("op_ready", 32'(op_ready), 32'(e_rdy));
         chk("mac_accu_rst", 32'(mac_accu_rst), 32'(m_cap));
         chk("res_valid", 32'(res_valid), 32'(!qe));
         if (!qe) begin
            chk("res_data", res_data, mq[0].d);
            chk("res_lane", 32'(res_lane), 32'(mq[0].l));
            chk("res_last", 32'(res_last), 32'(mq[0].last));
         end
`ifdef MAC_DRAIN_PERF_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
         if (op_valid && op_ready) iss_log.push_back(cyc);
         if (mac_accu_rst) arst_log.push_back(cyc);
         if (res_valid && res_ready) bl.push_back('{res_data, res_lane, res_last});
         // advance the model across the coming edge
         if (rst) begin
            mq.delete();
            m_after_rst = 1; m_closed = 0; m_cap = 0; m_n = 0; m_stall = 0;
         end else begin
            m_after_rst = 0;
            if (!qe && res_ready) void'(mq.pop_front());
            if (m_cap) begin
               push_lanes(z, m_aw);
               m_cap = 0; m_closed = 0;
            end else if (m_closed) begin
               if (cyc + 1 >= m_last_iss + LAT_EFF) begin
                  if (qe) m_cap = 1;
                  else    m_stall++;
               end
            end else if (e_rdy && op_valid) begin
               if (m_n == 0) begin
                  m_len = (acc_len == 0) ? 1 : int'(acc_len);
                  m_aw  = config_aw;
               end
               m_n++;
               if (m_n == m_len) begin
                  m_closed = 1; m_n = 0; m_last_iss = cyc;
               end
            end
         end
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic issue(input int n);
      int got = 0, g = 0;
      while (got < n) begin
         op_valid = 1;
         if (op_ready) got++;
         @(posedge clk); #1;
         if (++g > 200) begin tmo("issue"); break; end
      end
      op_valid = 0;
   endtask

   task automatic drain();
      int g = 0;
      while (!(op_ready && !res_valid)) begin
         @(posedge clk); #1;
         if (++g > 200) begin tmo("drain"); break; end
      end
   endtask

   task automatic do_rst();
      rst = 1; tick(1); rst = 0;
   endtask

   initial begin
      logic [31:0] e1 [4];
      int base, s, r, g;
      e1 = '{32'hFFFFFF80, 32'h00000001, 32'h0000007F, 32'hFFFFFFF0};

      @(posedge clk); #1;
      chk_en = 1;
      chk("rst_op_ready", 32'(op_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_last", 32'(res_last), 32'd0);
      tick(1); rst = 0;

      // 4-lane unpack
      res_ready = 1; config_aw = 3; acc_len = 1; z = 32'hF07F0180;
      tick(1); bl.delete();
      issue(1); drain();
      chk("t1_beats", 32'(bl.size()), 32'd4);
      for (int i = 0; i < 4 && i < bl.size(); i++) begin
         chk("t1_data", bl[i].d, e1[i]);
         chk("t1_lane", 32'(bl[i].l), 32'(i));
      end
      if (bl.size() == 4) chk("t1_last", 32'(bl[3].last), 32'd1);

      // 2-lane and 1-lane unpack
      bl.delete(); config_aw = 1; z = 32'h80001234;
      issue(1); drain();
      config_aw = 0; z = 32'h80000001;
      issue(1); drain();
      chk("t2_beats", 32'(bl.size()), 32'd3);
      if (bl.size() == 3) begin
         chk("t2_l0", bl[0].d, 32'h00001234);
         chk("t2_l1", bl[1].d, 32'hFFFF8000);
         chk("t2_l1_last", 32'(bl[1].last), 32'd1);
         chk("t2_1lane", bl[2].d, 32'h80000001);
         chk("t2_1lane_last", 32'(bl[2].last), 32'd1);
      end

      // burst timing, acc_len=3
      config_aw = 3; acc_len = 3; z = 32'h01020304;
      iss_log.delete(); arst_log.delete();
      base = cyc; op_valid = 1; tick(8); op_valid = 0;
      drain();
      if (iss_log.size() >= 4 && arst_log.size() >= 1) begin
         chk("t3_iss1", 32'(iss_log[1] - base), 32'd1);
         chk("t3_iss2", 32'(iss_log[2] - base), 32'd2);
         chk("t3_iss3", 32'(iss_log[3] - base), 32'd5);
         chk("t3_arst", 32'(arst_log[0] - base), 32'd4);
      end else tmo("t3_logs");

      // acc_len=0 acts as 1
      acc_len = 0; iss_log.delete(); arst_log.delete();
      issue(1); drain();
      chk("t3_len0_iss", 32'(iss_log.size()), 32'd1);
      if (iss_log.size() == 1 && arst_log.size() == 1)
         chk("t3_len0_lat", 32'(arst_log[0] - iss_log[0]), 32'd2);

      // backpressure
      do_rst();
      res_ready = 0; acc_len = 1; config_aw = 3; z = 32'hF07F0180;
      iss_log.delete(); bl.delete();
      issue(1); issue(1); tick(8);
      s = (iss_log.size() >= 2) ? iss_log[1] : 0;
      chk("t4_op_ready", 32'(op_ready), 32'd0);
      chk("t4_accu_rst", 32'(mac_accu_rst), 32'd0);
      chk("t4_valid", 32'(res_valid), 32'd1);
      chk("t4_data", res_data, 32'hFFFFFF80);
      r = cyc; res_ready = 1;
      drain();
      chk("t4_beats", 32'(bl.size()), 32'd8);
`ifdef MAC_DRAIN_PERF_EN
      chk("t4_stall", 32'(stall_cnt), 32'(r + 3 - s));
`endif

      // config change mid-burst
      bl.delete(); config_aw = 3; acc_len = 4; z = 32'h12345678;
      issue(1); config_aw = 0; acc_len = 1; issue(3); drain();
      chk("t5_beats", 32'(bl.size()), 32'd4);
      if (bl.size() == 4) chk("t5_last_lane", 32'(bl[3].l), 32'd3);
      issue(1); drain();
      chk("t5_next", 32'(bl.size()), 32'd5);
      if (bl.size() == 5) chk("t5_next_data", bl[4].d, 32'h12345678);

      // rst during FLUSH
      res_ready = 0; config_aw = 3;
      issue(1); issue(1); tick(3);
      do_rst();
      chk("t6_valid", 32'(res_valid), 32'd0);
      chk("t6_op_ready", 32'(op_ready), 32'd0);
      bl.delete(); res_ready = 1; tick(10);
      chk("t6_nobeats", 32'(bl.size()), 32'd0);

      // rst mid-serialization, after lane1
      bl.delete(); issue(1);
      g = 0;
      while (bl.size() < 2) begin
         tick(1);
         if (++g > 50) begin tmo("t6b_wait"); break; end
      end
      rst = 1; res_ready = 0; tick(1); rst = 0;
      chk("t6b_valid", 32'(res_valid), 32'd0);
      chk("t6b_op_ready", 32'(op_ready), 32'd0);
      res_ready = 1; tick(10);
      chk("t6b_beats", 32'(bl.size()), 32'd2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         op_valid  = ($urandom_range(0, 3) != 0);
         res_ready = ($urandom_range(0, 2) != 0);
         z         = $urandom;
         config_aw = 2'($urandom_range(0, 3));
         acc_len   = ALW'($urandom_range(0, 5));
         rst       = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      rst = 0; op_valid = 0; res_ready = 1;
      tick(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
